// File: rtl/dmem_responder_if.sv
// Memory-stage load/store bus between the pipeline (master) and dmem_responder (slave).
// Signals:
//   memreadM   - load request, held while stallM=1
//   memwriteM  - store request, held while stallM=1
//   aluoutM    - byte address
//   writedataM - store data
//   readdataM  - load data (registered in the slave)
//   stallM     - combinational pipeline hold from the slave
//   adrerrM    - one-cycle misaligned-access pulse
interface dmem_responder_if;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adrerrM;

    modport master (
        output memreadM, memwriteM, aluoutM, writedataM,
        input  readdataM, stallM, adrerrM
    );

    modport slave (
        input  memreadM, memwriteM, aluoutM, writedataM,
        output readdataM, stallM, adrerrM
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word RAM behind the M-stage load/store bus.
// Each access stalls the pipeline for the request cycle plus LATENCY wait states,
// then completes in a one-cycle DONE state.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of dmem_responder_if (request in, readdataM/stallM/adrerrM out)
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned idxW = $clog2(DEPTH);
    localparam int unsigned cntW = 4;

    typedef enum logic [1:0] {
        sIdle = 2'd0,
        sWait = 2'd1,
        sDone = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [cntW-1:0]   cnt;
    logic [cntW-1:0]   cntNext;
    logic              doAccess;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       readdataQ;
    logic              adrerrQ;

    logic              req;
    logic              misaligned;
    logic [idxW-1:0]   idx;
    logic              unusedAddr;

    // Request decode; upper address bits are dropped so addresses wrap modulo DEPTH
    assign req        = bus.memreadM | bus.memwriteM;
    assign misaligned = |bus.aluoutM[1:0];
    assign idx        = bus.aluoutM[idxW+1:2];
    assign unusedAddr = ^bus.aluoutM[31:idxW+2];

    // Next-state logic; doAccess marks the WAIT(cnt=0)->DONE edge where the access happens
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doAccess  = 1'b0;
        unique case (state)
            sIdle: begin
                if (req) begin
                    stateNext = sWait;
                    cntNext   = cntW'(LATENCY - 1);
                end
            end
            sWait: begin
                if (!req) begin
                    stateNext = sIdle;
                end else if (cnt == '0) begin
                    stateNext = sDone;
                    doAccess  = 1'b1;
                end else begin
                    cntNext = cnt - cntW'(1);
                end
            end
            sDone: begin
                stateNext = sIdle;
            end
            default: begin
                stateNext = sIdle;
            end
        endcase
    end

    // State, counter and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= sIdle;
            cnt       <= '0;
            readdataQ <= '0;
            adrerrQ   <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            adrerrQ <= doAccess & misaligned;
            if (doAccess) begin
                // A store also returns the pre-write word
                readdataQ <= misaligned ? 32'h0 : mem[idx];
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && doAccess && bus.memwriteM && !misaligned) begin
            mem[idx] <= bus.writedataM;
        end
    end

    assign bus.stallM    = req & (state != sDone);
    assign bus.readdataM = readdataQ;
    assign bus.adrerrM   = adrerrQ;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined MIPS core; it is the slave end of the memory-stage load/store interface. It accepts word read/write requests presented in the M stage, holds the pipeline with a stall output for a fixed number of wait states, and then completes the access. It contains a word-addressed RAM, a latency counter, a three-state FSM and a misaligned-address detector.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: wait states per access; range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- memreadM  in  1  load request; held stable by the pipeline while stallM=1.
- memwriteM  in  1  store request; held stable while stallM=1.
- aluoutM  in  32  byte address.
- writedataM  in  32  store data.
- readdataM  out  32  load data; registered.
- stallM  out  1  combinational; 1 holds the pipeline.
- adrerrM  out  1  registered; one-cycle pulse on a misaligned access.

## Operation
- Request: req = memreadM | memwriteM. If both are set, the access is a store; readdataM returns the pre-write word.
- Word index: aluoutM[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned: aluoutM[1:0] != 0. The access still takes the full latency. The store is suppressed, readdataM is loaded with 0, and adrerrM pulses in DONE.
- FSM states:
  - IDLE:
    - req=1 → WAIT, with cnt loaded with LATENCY-1.
    - req=0 → stay in IDLE.
  - WAIT:
    - req dropped (pipeline flush) → IDLE. Abort: no write, readdataM unchanged.
    - cnt=0 → DONE. On this edge the access is performed: a store writes the RAM, and a load (or the old word on a store) is captured into readdataM.
    - otherwise → cnt-1.
  - DONE: unconditionally → IDLE. The pipeline advances on this edge; a request visible during DONE is treated as already served.
- stallM = req & (state != DONE). It is 0 whenever req=0.
- adrerrM = 1 only during the DONE cycle of a misaligned access.
- RAM contents are not cleared by reset and are undefined before their first write.

## Timing
- Reset: state=IDLE, cnt=0, readdataM=0, adrerrM=0, so stallM=0 whenever req=0.
- Access timeline, with the request first seen at cycle 0 in IDLE:
  - stallM=1 in cycles 0..LATENCY.
  - DONE is reached in cycle LATENCY+1, where stallM=0 and readdataM is valid.
  - Total occupancy is LATENCY+2 cycles.
  - Example for LATENCY=2: stall in cycles 0,1,2; data valid in cycle 3.
- The RAM write and the readdataM update happen on the edge from WAIT(cnt=0) to DONE.
- readdataM holds its value until the next completed access or reset.
- Back-to-back requests: after DONE the FSM passes through IDLE for one cycle. A request held or presented in that IDLE cycle starts a new access with stallM=1 immediately. There is no bubble-free pipelining.
- Reset asserted mid-access (WAIT or DONE): next state is IDLE, no write occurs, readdataM=0.
- Reset has priority over every other input.

## Test plan
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10: stallM high for 3 cycles (request cycle + 2 wait states).
  - Then load 0x10: readdataM=0xDEADBEEF in DONE; stallM high 3 cycles per access.
- Back-to-back loads of 0x0 and 0x4, holding distinct data: each completes after its own 3-cycle stall, separated by exactly one IDLE cycle. readdataM changes only at the DONE edges.
- Misaligned store to 0x13 with data 0x1234, then load 0x10: adrerrM pulses for one cycle; the 0x10 word is unchanged; the misaligned access returns readdataM=0.
- Flush: load request dropped while in WAIT → stallM=0 the same cycle, state IDLE next cycle, readdataM keeps its previous value.
- Simultaneous memreadM=memwriteM=1 to 0x20 holding 0xA, writing 0xB: readdataM=0xA, and a subsequent load returns 0xB.
- Reset during WAIT of a store to 0x8: next cycle IDLE with readdataM=0; a subsequent load of 0x8 returns the pre-store value.
- Address wrap, DEPTH=64: a store to 0x100 is read back by a load of 0x0.
